// File: rtl/sample_player.sv
// rtl/sample_player.sv - single-channel sample ROM playback engine
module sample_player #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int SAMPLE_LEN = 48000,
    parameter int RATE_DIV   = 6250,
    parameter int LOOP       = 0
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  s_EN,
    input  logic                  s_reset,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] audio_out,
    output logic                  audio_valid,
    output logic                  playing,
    output logic                  done
);

    localparam int DIV_W = $clog2(RATE_DIV);
    localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(RATE_DIV - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SAMPLE_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_PAUSE,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [DIV_W-1:0]        divider, divider_d;
    logic                    rd_pending, rd_pending_d;
    logic                    reset_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [DATA_WIDTH-1:0]   audio_d;
    logic                    valid_d;
    logic                    done_d;
    logic                    start;
    logic                    tick;

    // reset_d powers up high so an s_reset already held at release is not a start
    assign start   = s_reset & ~reset_d;
    assign tick    = (divider == DIV_LAST);
    assign playing = (state_q == ST_PLAY);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            divider     <= '0;
            rd_pending  <= 1'b0;
            reset_d     <= 1'b1;
            rom_addr    <= '0;
            audio_out   <= '0;
            audio_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            divider     <= divider_d;
            rd_pending  <= rd_pending_d;
            reset_d     <= s_reset;
            rom_addr    <= addr_d;
            audio_out   <= audio_d;
            audio_valid <= valid_d;
            done        <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        divider_d    = divider;
        rd_pending_d = rd_pending;
        addr_d       = rom_addr;
        audio_d      = audio_out;
        valid_d      = 1'b0;
        done_d       = 1'b0;

        if (start) begin
            divider_d    = '0;
            rd_pending_d = 1'b0;
            addr_d       = '0;
            if (s_EN) begin
                state_d = ST_PLAY;
            end else begin
                state_d = ST_IDLE;
                audio_d = '0;
            end
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    audio_d = '0;
                end
                ST_PLAY: begin
                    if (!s_EN) begin
                        // Pausing drops an in-flight read; the same address is fetched again later
                        state_d      = ST_PAUSE;
                        rd_pending_d = 1'b0;
                        audio_d      = '0;
                    end else begin
                        divider_d    = tick ? '0 : divider + DIV_W'(1);
                        rd_pending_d = tick;
                        if (rd_pending) begin
                            audio_d = rom_data;
                            valid_d = 1'b1;
                            if (rom_addr == LAST_ADDR) begin
                                done_d = 1'b1;
                                if (LOOP != 0) begin
                                    addr_d = '0;
                                end else begin
                                    state_d = ST_DONE;
                                end
                            end else begin
                                addr_d = rom_addr + ADDR_WIDTH'(1);
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    if (s_EN) begin
                        state_d = ST_PLAY;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_player.sv
// tb/tb_sample_player.sv - bench for sample_player, one-shot and looping instances side by side
module tb_sample_player;

    localparam int RD  = 4;
    localparam int LEN = 8;
    localparam int M_IDLE  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        s_EN = 1'b0;
    logic        s_reset = 1'b0;

    logic [15:0] rom_addr_a, rom_data_a, audio_out_a;
    logic        audio_valid_a, playing_a, done_a;
    logic [15:0] rom_addr_b, rom_data_b, audio_out_b;
    logic        audio_valid_b, playing_b, done_b;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    sample_player #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .SAMPLE_LEN(LEN), .RATE_DIV(RD), .LOOP(0)) dut_a (
        .clock(clock), .resetn(resetn), .s_EN(s_EN), .s_reset(s_reset),
        .rom_addr(rom_addr_a), .rom_data(rom_data_a), .audio_out(audio_out_a),
        .audio_valid(audio_valid_a), .playing(playing_a), .done(done_a)
    );

    sample_player #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .SAMPLE_LEN(LEN), .RATE_DIV(RD), .LOOP(1)) dut_b (
        .clock(clock), .resetn(resetn), .s_EN(s_EN), .s_reset(s_reset),
        .rom_addr(rom_addr_b), .rom_data(rom_data_b), .audio_out(audio_out_b),
        .audio_valid(audio_valid_b), .playing(playing_b), .done(done_b)
    );

    always @(posedge clock) begin
        rom_data_a <= 16'h0010 + rom_addr_a;
        rom_data_b <= 16'h0010 + rom_addr_b;
    end

    // Model: countdown of playing edges until the next sample is delivered
    int          e_mode [2];
    int          e_wait [2];
    int          e_idx  [2];
    logic [15:0] e_audio[2];
    bit          e_valid[2];
    bit          e_done [2];
    bit          e_rsd;
    bit          m_start;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            e_rsd = 1'b1;
            for (int ch = 0; ch < 2; ch++) begin
                e_mode[ch] = M_IDLE; e_wait[ch] = 0; e_idx[ch] = 0;
                e_audio[ch] = 16'h0; e_valid[ch] = 1'b0; e_done[ch] = 1'b0;
            end
        end else begin
            m_start = s_reset && !e_rsd;
            e_rsd = s_reset;
            for (int ch = 0; ch < 2; ch++) begin
                e_valid[ch] = 1'b0;
                e_done[ch] = 1'b0;
                if (m_start) begin
                    e_idx[ch] = 0;
                    if (s_EN) begin
                        e_mode[ch] = M_PLAY;
                        e_wait[ch] = RD + 1;
                    end else begin
                        e_mode[ch] = M_IDLE;
                        e_audio[ch] = 16'h0;
                    end
                end else if (e_mode[ch] == M_IDLE || e_mode[ch] == M_DONE) begin
                    e_audio[ch] = 16'h0;
                end else if (e_mode[ch] == M_PAUSE) begin
                    if (s_EN) e_mode[ch] = M_PLAY;
                end else if (!s_EN) begin
                    e_mode[ch] = M_PAUSE;
                    e_audio[ch] = 16'h0;
                    if (e_wait[ch] == 1) e_wait[ch] = RD + 1;
                end else if (e_wait[ch] == 1) begin
                    e_audio[ch] = 16'h0010 + 16'(e_idx[ch]);
                    e_valid[ch] = 1'b1;
                    e_wait[ch] = RD;
                    if (e_idx[ch] == LEN - 1) begin
                        e_done[ch] = 1'b1;
                        if (ch == 1) e_idx[ch] = 0;
                        else e_mode[ch] = M_DONE;
                    end else begin
                        e_idx[ch] = e_idx[ch] + 1;
                    end
                end else begin
                    e_wait[ch] = e_wait[ch] - 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_ch(input int ch, input logic [15:0] addr, input logic [15:0] aud,
                          input logic vld, input logic ply, input logic dn);
        chk($sformatf("ch%0d rom_addr", ch), 32'(addr), 32'(e_idx[ch]));
        chk($sformatf("ch%0d audio_out", ch), 32'(aud), 32'(e_audio[ch]));
        chk($sformatf("ch%0d audio_valid", ch), 32'(vld), 32'(e_valid[ch]));
        chk($sformatf("ch%0d playing", ch), 32'(ply), 32'(e_mode[ch] == M_PLAY));
        chk($sformatf("ch%0d done", ch), 32'(dn), 32'(e_done[ch]));
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            cmp_ch(0, rom_addr_a, audio_out_a, audio_valid_a, playing_a, done_a);
            cmp_ch(1, rom_addr_b, audio_out_b, audio_valid_b, playing_b, done_b);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_valid(input int ch, output logic [15:0] v);
        bit got;
        got = 1'b0;
        v = 16'hffff;
        for (int i = 0; i < 40 && !got; i++) begin
            tick(1);
            if (ch == 0 && audio_valid_a) begin got = 1'b1; v = audio_out_a; end
            if (ch == 1 && audio_valid_b) begin got = 1'b1; v = audio_out_b; end
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_valid ch%0d: no audio_valid within 40 cycles at %0t", ch, $time);
        end
    endtask

    task automatic restart();
        s_reset = 1'b0;
        tick(1);
        s_reset = 1'b1;
        tick(1);
    endtask

    logic [15:0] v;
    int cnt_a, cnt_b, cnt_d;

    initial begin
        tick(3);
        chk_en = 1'b1;
        chk("reset playing", 32'(playing_a), 32'd0);
        chk("reset audio_out", 32'(audio_out_a), 32'd0);
        chk("reset rom_addr", 32'(rom_addr_a), 32'd0);
        resetn = 1'b1;
        tick(2);

        // 1: one-shot playback, exact cadence
        s_EN = 1'b1;
        s_reset = 1'b1;
        tick(1);
        chk("t1 playing after start", 32'(playing_a), 32'd1);
        tick(4);
        chk("t1 no valid at start+4", 32'(audio_valid_a), 32'd0);
        tick(1);
        chk("t1 valid at start+5", 32'(audio_valid_a), 32'd1);
        chk("t1 first sample", 32'(audio_out_a), 32'h10);
        for (int k = 1; k < LEN; k++) begin
            tick(3);
            chk($sformatf("t1 gap before %0d", k), 32'(audio_valid_a), 32'd0);
            tick(1);
            chk($sformatf("t1 valid %0d", k), 32'(audio_valid_a), 32'd1);
            chk($sformatf("t1 sample %0d", k), 32'(audio_out_a), 32'h10 + 32'(k));
        end
        chk("t1 done a", 32'(done_a), 32'd1);
        chk("t1 done b", 32'(done_b), 32'd1);
        chk("t4 playing b at end", 32'(playing_b), 32'd1);
        tick(1);
        chk("t1 audio zero after done", 32'(audio_out_a), 32'd0);
        chk("t1 playing zero after done", 32'(playing_a), 32'd0);
        wait_valid(1, v);
        chk("t4 b wraps to first sample", 32'(v), 32'h10);

        // 2: pause after third sample, resume re-reads from address 3
        restart();
        for (int k = 0; k < 3; k++) begin
            wait_valid(0, v);
            chk($sformatf("t2 sample %0d", k), 32'(v), 32'h10 + 32'(k));
        end
        s_EN = 1'b0;
        cnt_a = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (audio_valid_a) cnt_a++;
        end
        chk("t2 valid during pause", 32'(cnt_a), 32'd0);
        chk("t2 audio during pause", 32'(audio_out_a), 32'd0);
        chk("t2 rom_addr during pause", 32'(rom_addr_a), 32'd3);
        s_EN = 1'b1;
        for (int k = 3; k < LEN; k++) begin
            wait_valid(0, v);
            chk($sformatf("t2 resumed sample %0d", k), 32'(v), 32'h10 + 32'(k));
        end
        chk("t2 done at end", 32'(done_a), 32'd1);

        // 3: restart mid-play at address 5
        restart();
        for (int k = 0; k < 5; k++) wait_valid(0, v);
        chk("t3 rom_addr before restart", 32'(rom_addr_a), 32'd5);
        restart();
        for (int k = 0; k < LEN; k++) begin
            wait_valid(0, v);
            chk($sformatf("t3 replay sample %0d", k), 32'(v), 32'h10 + 32'(k));
        end
        chk("t3 done b with a", 32'(done_b), 32'd1);
        wait_valid(1, v);
        chk("t4 b wraps again", 32'(v), 32'h10);

        // 5: async reset mid-play, held s_reset is not a start
        restart();
        wait_valid(0, v);
        wait_valid(0, v);
        tick(2);
        resetn = 1'b0;
        #1;
        chk("t5 async audio a", 32'(audio_out_a), 32'd0);
        chk("t5 async addr a", 32'(rom_addr_a), 32'd0);
        chk("t5 async playing a", 32'(playing_a), 32'd0);
        chk("t5 async playing b", 32'(playing_b), 32'd0);
        chk("t5 async audio b", 32'(audio_out_b), 32'd0);
        tick(2);
        resetn = 1'b1;
        cnt_a = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (audio_valid_a || audio_valid_b) cnt_a++;
        end
        chk("t5 no valid with held s_reset", 32'(cnt_a), 32'd0);
        chk("t5 idle after release", 32'(playing_a), 32'd0);
        restart();
        wait_valid(0, v);
        chk("t5 first sample after new start", 32'(v), 32'h10);

        // 6: s_reset held high 50 cycles gives exactly one start
        s_reset = 1'b0;
        tick(1);
        s_reset = 1'b1;
        cnt_a = 0; cnt_b = 0; cnt_d = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (audio_valid_a) cnt_a++;
            if (audio_valid_b) cnt_b++;
            if (done_a) cnt_d++;
        end
        chk("t6 one-shot valid count", 32'(cnt_a), 32'd8);
        chk("t6 one-shot done count", 32'(cnt_d), 32'd1);
        chk("t6 loop valid count", 32'(cnt_b), 32'd12);
        s_EN = 1'b0;
        restart();
        chk("t6 start with EN low addr a", 32'(rom_addr_a), 32'd0);
        chk("t6 start with EN low addr b", 32'(rom_addr_b), 32'd0);
        chk("t6 start with EN low playing", 32'(playing_a), 32'd0);
        chk("t6 start with EN low audio", 32'(audio_out_a), 32'd0);
        cnt_a = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (audio_valid_a || audio_valid_b) cnt_a++;
        end
        chk("t6 idle stays silent", 32'(cnt_a), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
